bcd_timer: RTL and testbench

Parametrised mm:ss BCD timer with run control, preset load and up/down counting. It generalises the free-running seconds/minutes digit chain into a controllable stopwatch/countdown: an internal prescaler derives the one-second tick from `clk`, and a small FSM gates counting. The block sits between the board's button/switch debouncers and the seven-segment display driver.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_timer.sv | 140 ++++++++++++++
 tb/tb_bcd_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        DONE     = 2'd3
    } timer_state_e;

    localparam int UNITS_MAX = 9;
    localparam int TENS_MAX  = 5;

    // Decoded commands after priority resolution; at most one bit is set.
    typedef struct packed {
        logic clear;
        logic load;
        logic stop;
        logic start;
    } timer_cmd_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] max);
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer chain: counts 0..MAX up or down, with clear and load.
module bcd_digit
    import timer_pkg::*;
#(
    parameter int MAX = UNITS_MAX,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         down,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         co
);

    localparam logic [W-1:0] QMAX = W'(MAX);

    // Carry/borrow is independent of en so the chain enable can be ANDed downstream.
    assign co = down ? (q == '0) : (q == QMAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            if (down)
                q <= (q == '0) ? QMAX : q - W'(1);
            else
                q <= (q == QMAX) ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/bcd_timer.sv
// mm:ss BCD stopwatch/countdown: prescaler, run-control FSM and a four-digit BCD chain.
module bcd_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100,
    parameter bit WRAP     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic       dir,
    input  logic [2:0] preset_min_tens,
    input  logic [3:0] preset_min_units,
    input  logic [2:0] preset_sec_tens,
    input  logic [3:0] preset_sec_units,
    output logic [2:0] min_tens,
    output logic [3:0] min_units,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       done,
    output logic       tick
);

    localparam int            DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    timer_state_e  state;
    logic [DW-1:0] div_cnt;
    timer_cmd_t    cmd;
    logic          run_st, cmd_any, tick_due, step, count_down;
    logic          is_zero, is_max, is_one, sat_hold;
    logic          co_su, co_st, co_mu, co_mt;
    logic          en_st, en_mu, en_mt;
    logic [2:0]    p_mt, p_st;
    logic [3:0]    p_mu, p_su;

    assign run_st     = (state == RUN_UP) || (state == RUN_DOWN);
    assign count_down = (state == RUN_DOWN);

    always_comb begin
        cmd       = '0;
        cmd.clear = clear;
        cmd.load  = load & ~clear;
        cmd.stop  = stop & ~clear & ~load & run_st;
        cmd.start = start & ~clear & ~load & ~stop & (state == IDLE);
    end

    assign cmd_any = |cmd;

    assign is_zero = (min_tens == 3'd0) && (min_units == 4'd0) &&
                     (sec_tens == 3'd0) && (sec_units == 4'd0);
    assign is_one  = (min_tens == 3'd0) && (min_units == 4'd0) &&
                     (sec_tens == 3'd0) && (sec_units == 4'd1);
    assign is_max  = (min_tens == 3'(TENS_MAX)) && (min_units == 4'(UNITS_MAX)) &&
                     (sec_tens == 3'(TENS_MAX)) && (sec_units == 4'(UNITS_MAX));

    // Saturating mode freezes the digits at 59:59 while still issuing the final tick.
    assign sat_hold = (state == RUN_UP) && is_max && !WRAP;
    assign tick_due = run_st && (div_cnt == DIV_LAST);
    assign step     = tick_due && !cmd_any && !sat_hold;

    assign en_st = step  & co_su;
    assign en_mu = en_st & co_st;
    assign en_mt = en_mu & co_mu;

    assign p_mt = 3'(clamp_digit({1'b0, preset_min_tens}, 4'(TENS_MAX)));
    assign p_mu = clamp_digit(preset_min_units, 4'(UNITS_MAX));
    assign p_st = 3'(clamp_digit({1'b0, preset_sec_tens}, 4'(TENS_MAX)));
    assign p_su = clamp_digit(preset_sec_units, 4'(UNITS_MAX));

    bcd_digit #(.MAX(UNITS_MAX), .W(4)) u_sec_units (
        .clk(clk), .reset(reset), .en(step), .down(count_down), .load(cmd.load),
        .d(p_su), .clr(cmd.clear), .q(sec_units), .co(co_su)
    );

    bcd_digit #(.MAX(TENS_MAX), .W(3)) u_sec_tens (
        .clk(clk), .reset(reset), .en(en_st), .down(count_down), .load(cmd.load),
        .d(p_st), .clr(cmd.clear), .q(sec_tens), .co(co_st)
    );

    bcd_digit #(.MAX(UNITS_MAX), .W(4)) u_min_units (
        .clk(clk), .reset(reset), .en(en_mu), .down(count_down), .load(cmd.load),
        .d(p_mu), .clr(cmd.clear), .q(min_units), .co(co_mu)
    );

    bcd_digit #(.MAX(TENS_MAX), .W(3)) u_min_tens (
        .clk(clk), .reset(reset), .en(en_mt), .down(count_down), .load(cmd.load),
        .d(p_mt), .clr(cmd.clear), .q(min_tens), .co(co_mt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            tick    <= 1'b0;
            div_cnt <= '0;
        end else begin
            tick <= 1'b0;
            if (cmd.clear || cmd.load || cmd.stop) begin
                state   <= IDLE;
                running <= 1'b0;
                done    <= 1'b0;
                div_cnt <= '0;
            end else if (cmd.start) begin
                div_cnt <= '0;
                if (!dir) begin
                    state   <= RUN_UP;
                    running <= 1'b1;
                end else if (is_zero) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    state   <= RUN_DOWN;
                    running <= 1'b1;
                end
            end else if (run_st) begin
                if (tick_due) begin
                    div_cnt <= '0;
                    tick    <= 1'b1;
                    // Terminal update and DONE entry share the same edge.
                    if (sat_hold || (count_down && is_one)) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end else begin
                div_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer.sv
// Randomized + directed bench for bcd_timer; a seconds-based model tracks two DUT variants.
module tb_bcd_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
    logic [2:0] pmt = '0, pst = '0;
    logic [3:0] pmu = '0, psu = '0;

    logic [2:0] o_mt [2];
    logic [3:0] o_mu [2];
    logic [2:0] o_st [2];
    logic [3:0] o_su [2];
    logic       o_run [2];
    logic       o_done [2];
    logic       o_tick [2];

    int  n_chk = 0, n_fail = 0;
    bit  chk_on = 1'b0;

    int  tdiv [2] = '{4, 3};
    bit  wrap [2] = '{1'b1, 1'b0};
    int  m_sec [2];
    int  m_st [2];   // 0 idle, 1 up, 2 down, 3 done
    int  m_cnt [2];
    bit  m_tick [2];

    always #5 clk = ~clk;

    bcd_timer #(.TICK_DIV(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .reset(rst_n), .start(start), .stop(stop), .clear(clear), .load(load), .dir(dir),
        .preset_min_tens(pmt), .preset_min_units(pmu), .preset_sec_tens(pst), .preset_sec_units(psu),
        .min_tens(o_mt[0]), .min_units(o_mu[0]), .sec_tens(o_st[0]), .sec_units(o_su[0]),
        .running(o_run[0]), .done(o_done[0]), .tick(o_tick[0])
    );

    bcd_timer #(.TICK_DIV(3), .WRAP(1'b0)) dut_b (
        .clk(clk), .reset(rst_n), .start(start), .stop(stop), .clear(clear), .load(load), .dir(dir),
        .preset_min_tens(pmt), .preset_min_units(pmu), .preset_sec_tens(pst), .preset_sec_units(psu),
        .min_tens(o_mt[1]), .min_units(o_mu[1]), .sec_tens(o_st[1]), .sec_units(o_su[1]),
        .running(o_run[1]), .done(o_done[1]), .tick(o_tick[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cl(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [13:0] digits(input int sec);
        int mm, ss;
        mm = sec / 60;
        ss = sec % 60;
        return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [13:0] dut_val(input int i);
        return {o_mt[i], o_mu[i], o_st[i], o_su[i]};
    endfunction

    task automatic model_step(input int i);
        bit run;
        run = (m_st[i] == 1) || (m_st[i] == 2);
        m_tick[i] = 1'b0;
        if (clear) begin
            m_sec[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
        end else if (load) begin
            m_sec[i] = cl(int'(pmt), 5) * 600 + cl(int'(pmu), 9) * 60 + cl(int'(pst), 5) * 10 + cl(int'(psu), 9);
            m_st[i] = 0; m_cnt[i] = 0;
        end else if (stop && run) begin
            m_st[i] = 0; m_cnt[i] = 0;
        end else if (start && !stop && m_st[i] == 0) begin
            m_cnt[i] = 0;
            if (!dir)             m_st[i] = 1;
            else if (m_sec[i] == 0) m_st[i] = 3;
            else                  m_st[i] = 2;
        end else if (run) begin
            if (m_cnt[i] == tdiv[i] - 1) begin
                m_cnt[i] = 0;
                m_tick[i] = 1'b1;
                if (m_st[i] == 1) begin
                    if (m_sec[i] == 3599) begin
                        if (wrap[i]) m_sec[i] = 0;
                        else         m_st[i] = 3;
                    end else begin
                        m_sec[i]++;
                    end
                end else begin
                    m_sec[i]--;
                    if (m_sec[i] == 0) m_st[i] = 3;
                end
            end else begin
                m_cnt[i]++;
            end
        end else begin
            m_cnt[i] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_sec[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_tick[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.val", i), 32'(dut_val(i)), 32'(digits(m_sec[i])));
                check($sformatf("u%0d.running", i), 32'(o_run[i]), 32'((m_st[i] == 1) || (m_st[i] == 2)));
                check($sformatf("u%0d.done", i), 32'(o_done[i]), 32'(m_st[i] == 3));
                check($sformatf("u%0d.tick", i), 32'(o_tick[i]), 32'(m_tick[i]));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit c, input bit l, input bit sp, input bit st, input bit d);
        @(negedge clk);
        clear = c; load = l; stop = sp; start = st; dir = d;
        @(negedge clk);
        clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
    endtask

    task automatic load_val(input int mt, input int mu, input int st, input int su);
        pmt = 3'(mt); pmu = 4'(mu); pst = 3'(st); psu = 4'(su);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    localparam logic [13:0] V5959 = {3'd5, 4'd9, 3'd5, 4'd9};

    initial begin
        #12;
        for (int i = 0; i < 2; i++) begin
            check("rst.val", 32'(dut_val(i)), 32'd0);
            check("rst.running", 32'(o_run[i]), 32'd0);
            check("rst.done", 32'(o_done[i]), 32'd0);
            check("rst.tick", 32'(o_tick[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // count up from clear, then the 00:58 -> 01:00 carry
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(20);
        load_val(0, 0, 5, 8);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(12);

        // wrap vs saturate at 59:59
        load_val(5, 9, 5, 8);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(15);
        check("wrap.running", 32'(o_run[0]), 32'd1);
        check("sat.done", 32'(o_done[1]), 32'd1);
        check("sat.val", 32'(dut_val(1)), 32'(V5959));

        // countdown from 01:01; start in DONE is ignored
        load_val(0, 1, 0, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycles(61 * 4 + 6);
        check("down.done", 32'(o_done[0]), 32'd1);
        check("down.val", 32'(dut_val(0)), 32'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(6);
        check("done.sticky", 32'(o_done[0]), 32'd1);

        // stop+start together in IDLE: stop wins, nothing starts
        load_val(0, 0, 1, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycles(8);
        check("stopstart.running", 32'(o_run[0]), 32'd0);

        // stop landing on a tick edge of unit 0
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(2);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycles(6);
        check("stoptick.val", 32'(dut_val(0)), 32'(digits(10)));

        // clamped preset, then start down at 00:00
        load_val(7, 15, 7, 15);
        check("clamp.val", 32'(dut_val(0)), 32'(V5959));
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("zerodown.done", 32'(o_done[0]), 32'd1);

        // asynchronous reset mid-count at 12:34
        load_val(1, 2, 3, 4);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("amid.val", 32'(dut_val(i)), 32'd0);
            check("amid.running", 32'(o_run[i]), 32'd0);
            check("amid.done", 32'(o_done[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // random command soup
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            clear = ($urandom_range(0, 99) < 2);
            load  = ($urandom_range(0, 99) < 4);
            stop  = ($urandom_range(0, 99) < 4);
            start = ($urandom_range(0, 99) < 8);
            dir   = 1'($urandom);
            pmt   = 3'($urandom);
            pmu   = 4'($urandom);
            pst   = 3'($urandom);
            psu   = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
        cycles(4);
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
